param_dpram: RTL and testbench
==============================

PARAM_DPRAM -- requirements
Module: param_dpram

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and give the word width in bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 The parameter ADDR_W SHALL default to 8 and give the address width, with depth DEPTH = 2**ADDR_W words.
REQ-003 The parameter RDW_MODE SHALL default to 0 and select read-during-write to the same address: 0 = old data, 1 = new data (write-through).
REQ-004 The parameter OUT_REG SHALL default to 0 and select read latency: 0 = 1 cycle, 1 = 2 cycles through an extra output register.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr  input  1  write request.
REQ-008 w_addr  input  ADDR_W  write address.
REQ-009 din  input  DATA_W  write data.
REQ-010 wr_be  input  DATA_W/8  byte enables; bit k SHALL enable din[8k+7:8k].
REQ-011 rd  input  1  read request.
REQ-012 r_addr  input  ADDR_W  read address.
REQ-013 dout  output  DATA_W  registered read data.
REQ-014 dout_valid  output  1  high for exactly one cycle per accepted read, aligned with its data on dout.
REQ-015 init_busy  output  1  high while the memory clear sweep runs.

Function
REQ-016 The block SHALL contain a two-state FSM with states INIT and RUN.
REQ-017 In INIT, the block SHALL write zero to one address per cycle, ascending from 0, using an ADDR_W-bit sweep counter.
REQ-018 INIT SHALL go to RUN on the cycle after address DEPTH-1 is cleared, so a full sweep takes exactly DEPTH cycles.
REQ-019 init_busy SHALL be 1 in INIT and 0 in RUN.
REQ-020 In INIT, wr and rd SHALL be ignored: no user write takes effect, no read is accepted, and dout_valid stays 0.
REQ-021 In RUN, a write with wr=1 SHALL update only the bytes of mem[w_addr] whose wr_be bit is 1; wr=1 with wr_be all zero SHALL leave memory unchanged.
REQ-022 In RUN, a read with rd=1 in cycle N SHALL present mem[r_addr] on dout with dout_valid=1 at cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
REQ-023 When no read is accepted, dout SHALL hold its last value and dout_valid SHALL be 0.
REQ-024 A read and a write to the same address in the same cycle with RDW_MODE=0 SHALL return the pre-write word.
REQ-025 A read and a write to the same address in the same cycle with RDW_MODE=1 SHALL return the old word with the byte-enabled bytes replaced by din.
REQ-026 A read and a write to different addresses in the same cycle SHALL both complete independently.
REQ-027 Back-to-back reads on every cycle SHALL be supported at full throughput, one word per cycle.
REQ-028 The sweep counter SHALL NOT wrap back into INIT; RUN SHALL persist until the next reset.

Reset
REQ-029 rst=1 sampled on a clock edge SHALL set the FSM to INIT, the sweep counter to 0, dout to 0, dout_valid to 0, and all output-pipeline valid bits to 0; init_busy SHALL be 1 on the following cycle.
REQ-030 rst asserted mid-sweep SHALL restart the sweep at address 0.
REQ-031 rst asserted in RUN SHALL discard any in-flight read and produce no dout_valid pulse for it.
REQ-032 The INIT clear SHALL be the only mechanism that zeroes memory; no single-cycle whole-array reset SHALL be used.

Verification
REQ-033 Reset clear: pulse rst for 1 cycle -> init_busy high for exactly 256 cycles; then reading addresses 0, 127 and 255 -> dout=0x0000 with dout_valid.
REQ-034 Byte-enable write: write 0xABCD with wr_be=2'b11 to addr 0x10, then 0x1200 with wr_be=2'b10, then read addr 0x10 -> dout=0x12CD.
REQ-035 Read-during-write: mem[5]=0x1111; in one cycle write 0x2222 (wr_be=2'b11) and read addr 5 -> dout=0x1111 (RDW_MODE=0) or 0x2222 (RDW_MODE=1); a later read -> 0x2222.
REQ-036 Latency and throughput: OUT_REG=1, reads of addr 1,2,3 on consecutive cycles -> dout_valid high on cycles N+2..N+4 with data in order.
REQ-037 Ignored access during init: wr=1 to addr 0x00 with din=0xFFFF during INIT -> after INIT, a read of addr 0x00 returns 0x0000.
REQ-038 Reset mid-sweep: assert rst at sweep address 100 -> init_busy stays high for 256 further cycles, and an in-flight read produces no dout_valid.

Source files
------------

// File: rtl/param_dpram.sv
// Byte-enabled simple dual-port RAM with a self-clearing power-up sweep,
// selectable read-during-write behaviour and optional output register.
module param_dpram #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  init_busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;

  logic                rd_go;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_fwd;

  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]   s1_data_q, s1_data_d;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = RUN;
      end
      RUN: begin
        sweep_d = sweep_q;
      end
      default: begin
        state_d = INIT;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign init_busy = (state_q == INIT);

  // The clear sweep owns the write port until RUN
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = w_addr;
    mem_wdata = din;
    mem_be    = wr_be;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_go = (state_q == RUN) && rd;

  always_comb begin
    rd_word = mem[r_addr];
    rd_fwd  = rd_word;
    if ((RDW_MODE != 0) && wr && (w_addr == r_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) rd_fwd[8*b +: 8] = din[8*b +: 8];
      end
    end
  end

  always_comb begin
    s1_valid_d = rd_go;
    s1_data_d  = rd_go ? rd_fwd : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign dout       = s2_data_q;
    assign dout_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign dout       = s1_data_q;
    assign dout_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_param_dpram.sv
// Bench for param_dpram: two instances (old-data/1-cycle and
// write-through/2-cycle) driven in parallel against a behavioural model.
module tb_param_dpram;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wr;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] din;
  logic [1:0]    wr_be;
  logic          rd;
  logic [AW-1:0] r_addr;

  logic [DW-1:0] dout_a, dout_b;
  logic          valid_a, valid_b;
  logic          busy_a, busy_b;

  param_dpram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst(rst), .wr(wr), .w_addr(w_addr), .din(din),
    .wr_be(wr_be), .rd(rd), .r_addr(r_addr), .dout(dout_a),
    .dout_valid(valid_a), .init_busy(busy_a)
  );

  param_dpram #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1)) u_b (
    .clk(clk), .rst(rst), .wr(wr), .w_addr(w_addr), .din(din),
    .wr_be(wr_be), .rd(rd), .r_addr(r_addr), .dout(dout_b),
    .dout_valid(valid_b), .init_busy(busy_b)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  rd_t           qa[$];
  rd_t           qb[$];
  int            busy_left;
  int            cyc;
  int            errors;
  int            checks;
  logic [DW-1:0] last_a, last_b, exp_da, exp_db;
  logic          exp_va, exp_vb, exp_busy;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old,
                                          logic [DW-1:0] nw,
                                          logic [1:0] be);
    for (int k = 0; k < 2; k++) begin
      if (be[k]) old[8*k +: 8] = nw[8*k +: 8];
    end
    return old;
  endfunction

  // One clock: apply the model to the inputs seen at this edge, then sample.
  task automatic tick();
    logic [DW-1:0] old;
    @(posedge clk);
    cyc++;
    if (rst) begin
      busy_left = DEPTH;
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (rd) begin
        old = mem_m[r_addr];
        qa.push_back(rd_t'{cyc, old});
        qb.push_back(rd_t'{cyc + 1,
          (wr && w_addr == r_addr) ? merge(old, din, wr_be) : old});
      end
      if (wr) mem_m[w_addr] = merge(mem_m[w_addr], din, wr_be);
    end
    exp_va = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      exp_va = 1'b1;
      last_a = qa[0].d;
      void'(qa.pop_front());
    end
    exp_vb = 1'b0;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      exp_vb = 1'b1;
      last_b = qb[0].d;
      void'(qb.pop_front());
    end
    exp_da   = last_a;
    exp_db   = last_b;
    exp_busy = (busy_left > 0);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int addrs[3];
    addrs = '{0, 127, 255};
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || valid_a !== 1'b0 ||
        valid_b !== 1'b0 || dout_a !== '0 || dout_b !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b/%b valid=%b/%b dout=%h/%h required busy=1 valid=0 dout=0",
               busy_a, busy_b, valid_a, valid_b, dout_a, dout_b);
    end
    n = 1;
    wr = 1'b1; w_addr = 8'h00; din = 16'hFFFF; wr_be = 2'b11;
    rd = 1'b1; r_addr = 8'h00;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy_a) break;
      n++;
      checks++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0 || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL init_ignore: cyc=%0d valid=%b/%b busy_b=%b required 0/0/1",
                 cyc, valid_a, valid_b, busy_b);
      end
    end
    idle();
    checks++;
    if (n != DEPTH || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL init_length: busy cycles=%0d busy_b=%b required %0d and 0",
               n, busy_b, DEPTH);
    end
    foreach (addrs[i]) begin
      rd = 1'b1;
      r_addr = AW'(addrs[i]);
      tick();
      rd = 1'b0;
      checks++;
      if (valid_a !== 1'b1 || dout_a !== 16'h0000) begin
        errors++;
        $display("FAIL clear_read_a: addr=%0d valid=%b dout=%h required 1 0000",
                 addrs[i], valid_a, dout_a);
      end
      tick();
      checks++;
      if (valid_b !== 1'b1 || dout_b !== 16'h0000 || valid_a !== 1'b0) begin
        errors++;
        $display("FAIL clear_read_b: addr=%0d valid_b=%b dout_b=%h valid_a=%b required 1 0000 0",
                 addrs[i], valid_b, dout_b, valid_a);
      end
    end
  endtask

  task automatic test_byte_enable();
    wr = 1'b1; w_addr = 8'h10; din = 16'hABCD; wr_be = 2'b11;
    tick();
    din = 16'h1200; wr_be = 2'b10;
    tick();
    wr = 1'b0;
    rd = 1'b1; r_addr = 8'h10;
    tick();
    rd = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 16'h12CD) begin
      errors++;
      $display("FAIL byte_en_a: valid=%b dout=%h required 1 12cd", valid_a, dout_a);
    end
    tick();
    checks++;
    if (valid_b !== 1'b1 || dout_b !== 16'h12CD ||
        valid_a !== 1'b0 || dout_a !== 16'h12CD) begin
      errors++;
      $display("FAIL byte_en_b: valid_b=%b dout_b=%h valid_a=%b dout_a=%h required 1 12cd 0 12cd",
               valid_b, dout_b, valid_a, dout_a);
    end
    wr = 1'b1; w_addr = 8'h11; din = 16'h5678; wr_be = 2'b00;
    tick();
    wr = 1'b0;
    rd = 1'b1; r_addr = 8'h11;
    tick();
    rd = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 16'h0000) begin
      errors++;
      $display("FAIL zero_be: valid=%b dout=%h required 1 0000", valid_a, dout_a);
    end
    tick();
  endtask

  task automatic test_rdw();
    wr = 1'b1; w_addr = 8'h05; din = 16'h1111; wr_be = 2'b11;
    tick();
    din = 16'h2222;
    rd = 1'b1; r_addr = 8'h05;
    tick();
    idle();
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 16'h1111) begin
      errors++;
      $display("FAIL rdw_old: valid=%b dout=%h required 1 1111", valid_a, dout_a);
    end
    tick();
    checks++;
    if (valid_b !== 1'b1 || dout_b !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_new: valid=%b dout=%h required 1 2222", valid_b, dout_b);
    end
    rd = 1'b1; r_addr = 8'h05;
    tick();
    rd = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_later_a: valid=%b dout=%h required 1 2222", valid_a, dout_a);
    end
    tick();
    checks++;
    if (valid_b !== 1'b1 || dout_b !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_later_b: valid=%b dout=%h required 1 2222", valid_b, dout_b);
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] w[4];
    logic          ea_v, eb_v;
    logic [DW-1:0] ea_d, eb_d;
    for (int i = 1; i <= 3; i++) begin
      w[i] = DW'($urandom);
      wr = 1'b1; w_addr = AW'(i); din = w[i]; wr_be = 2'b11;
      tick();
    end
    idle();
    for (int t = 1; t <= 5; t++) begin
      if (t <= 3) begin
        rd = 1'b1;
        r_addr = AW'(t);
      end else begin
        rd = 1'b0;
      end
      tick();
      ea_v = (t <= 3);
      ea_d = w[(t <= 3) ? t : 3];
      eb_v = (t >= 2 && t <= 4);
      eb_d = w[(t >= 4) ? 3 : ((t >= 2) ? t - 1 : 1)];
      checks++;
      if (valid_a !== ea_v || dout_a !== ea_d) begin
        errors++;
        $display("FAIL latency_a: t=%0d valid=%b dout=%h required %b %h",
                 t, valid_a, dout_a, ea_v, ea_d);
      end
      checks++;
      if (valid_b !== eb_v || (t >= 2 && dout_b !== eb_d)) begin
        errors++;
        $display("FAIL latency_b: t=%0d valid=%b dout=%h required %b %h",
                 t, valid_b, dout_b, eb_v, eb_d);
      end
    end
  endtask

  task automatic test_diff_addr();
    logic [DW-1:0] v1, v2;
    v1 = DW'($urandom);
    v2 = DW'($urandom);
    wr = 1'b1; w_addr = 8'h20; din = v1; wr_be = 2'b11;
    tick();
    w_addr = 8'h21; din = v2; wr_be = 2'b01;
    rd = 1'b1; r_addr = 8'h20;
    tick();
    wr = 1'b0;
    r_addr = 8'h21;
    checks++;
    if (valid_a !== 1'b1 || dout_a !== v1) begin
      errors++;
      $display("FAIL diff_addr_rd: valid=%b dout=%h required 1 %h", valid_a, dout_a, v1);
    end
    tick();
    rd = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || dout_a !== {8'h00, v2[7:0]}) begin
      errors++;
      $display("FAIL diff_addr_wr: valid=%b dout=%h required 1 %h",
               valid_a, dout_a, {8'h00, v2[7:0]});
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      wr     = 1'($urandom_range(0, 1));
      w_addr = AW'($urandom_range(0, 7));
      din    = DW'($urandom);
      wr_be  = 2'($urandom_range(0, 3));
      rd     = ($urandom_range(0, 3) != 0);
      r_addr = AW'($urandom_range(0, 7));
      tick();
      checks++;
      if (valid_a !== exp_va || dout_a !== exp_da || busy_a !== exp_busy) begin
        errors++;
        $display("FAIL random_a: cyc=%0d valid=%b dout=%h busy=%b required %b %h %b",
                 cyc, valid_a, dout_a, busy_a, exp_va, exp_da, exp_busy);
      end
      checks++;
      if (valid_b !== exp_vb || dout_b !== exp_db || busy_b !== exp_busy) begin
        errors++;
        $display("FAIL random_b: cyc=%0d valid=%b dout=%h busy=%b required %b %h %b",
                 cyc, valid_b, dout_b, busy_b, exp_vb, exp_db, exp_busy);
      end
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rd = 1'b1; r_addr = 8'h03;
    tick();
    rd = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (valid_b !== 1'b0 || dout_b !== '0 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL inflight_drop: valid_b=%b dout_b=%h busy=%b/%b required 0 0000 1/1",
               valid_b, dout_b, busy_a, busy_b);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL sweep_partial: i=%0d valid=%b/%b busy=%b/%b required 0/0 1/1",
                 i, valid_a, valid_b, busy_a, busy_b);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy_a) break;
      n++;
    end
    checks++;
    if (n != DEPTH || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL restart_length: busy cycles=%0d busy_b=%b required %0d and 0",
               n, busy_b, DEPTH);
    end
    rd = 1'b1; r_addr = 8'h10;
    tick();
    r_addr = 8'h05;
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 16'h0000) begin
      errors++;
      $display("FAIL recleared_a: valid=%b dout=%h required 1 0000", valid_a, dout_a);
    end
    tick();
    rd = 1'b0;
    checks++;
    if (valid_b !== 1'b1 || dout_b !== 16'h0000) begin
      errors++;
      $display("FAIL recleared_b: valid=%b dout=%h required 1 0000", valid_b, dout_b);
    end
    tick();
    checks++;
    if (valid_b !== 1'b1 || dout_b !== 16'h0000 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL recleared_b2: valid_b=%b dout_b=%h valid_a=%b required 1 0000 0",
               valid_b, dout_b, valid_a);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    busy_left = DEPTH;
    last_a = '0;
    last_b = '0;
    rst    = 1'b1;
    wr     = 1'b0;
    rd     = 1'b0;
    w_addr = '0;
    r_addr = '0;
    din    = '0;
    wr_be  = '0;
    test_reset();
    test_byte_enable();
    test_rdw();
    test_latency();
    test_diff_addr();
    test_random();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
